// File: rtl/mdio_master_pkg.sv
// Shared definitions for the MDIO management-interface master.
// Holds FSM state codes, frame start/opcode values, field lengths, the
// command payload struct and small opcode-decoding helpers.
package mdio_master_pkg;

    // FSM state codes
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Start-of-frame codes
    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    // Opcodes
    localparam logic [1:0] OP_C22_WRITE = 2'b01;
    localparam logic [1:0] OP_C22_READ  = 2'b10;
    localparam logic [1:0] OP_C45_ADDR  = 2'b00;
    localparam logic [1:0] OP_C45_WRITE = 2'b01;
    localparam logic [1:0] OP_C45_RDINC = 2'b10;
    localparam logic [1:0] OP_C45_READ  = 2'b11;

    // Field lengths in MDC bit periods
    localparam int unsigned PRE_BITS   = 32;
    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned HDR_BITS   = 14;
    localparam int unsigned TA_BITS    = 2;
    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned BIT_CNT_W  = 5;

    // Captured command payload
    typedef struct packed {
        logic        c45;
        logic [1:0]  op;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [15:0] wdata;
    } mdio_cmd_t;

    // Read ops turn the line around after the header
    function automatic logic op_is_read(input logic c45, input logic [1:0] op);
        if (c45) begin
            return (op == OP_C45_READ) || (op == OP_C45_RDINC);
        end
        return op == OP_C22_READ;
    endfunction

    // Clause 22 only defines write and read; the other two codes have no frame
    function automatic logic op_is_legal(input logic c45, input logic [1:0] op);
        return c45 || (op == OP_C22_WRITE) || (op == OP_C22_READ);
    endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC clock generator.
// Ports: clk_i/rst_i (sync, active-high), run_i enables toggling;
// mdc_o registered clock, rise_en_c_o / fall_en_c_o flag the cycle whose
// closing edge makes mdc rise / fall. Counter and mdc clear when run_i drops.
module mdio_mdc_gen #(
    parameter int unsigned MDC_DIV = 80
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic mdc_o,
    output logic rise_en_c_o,
    output logic fall_en_c_o
);

    localparam int unsigned HALF  = MDC_DIV / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdc_q, mdc_d;
    logic             tick_c;

    // Half-period counter; tick marks the last cycle of each half period
    always_comb begin
        tick_c      = run_i && (cnt_q == CNT_W'(HALF - 1));
        cnt_d       = (run_i && !tick_c) ? cnt_q + CNT_W'(1) : '0;
        mdc_d       = run_i ? (mdc_q ^ tick_c) : 1'b0;
        rise_en_c_o = tick_c && !mdc_q;
        fall_en_c_o = tick_c && mdc_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc_o = mdc_q;

endmodule

// File: rtl/mdio_master.sv
// MDIO (Clause 22 / Clause 45) management master.
// Ports: clk_200m, rst_200m (sync, active-high); cmd_* request with
// valid/ready handshake; preamble_suppress, opendrain_mode line options;
// mdc, mdio_out, mdio_oen (active-low), mdio_in line pins;
// rsp_valid pulse with rsp_rdata / rsp_err; busy while a frame runs.
module mdio_master
    import mdio_master_pkg::*;
#(
    parameter int unsigned MDC_DIV = 80
) (
    input  logic        clk_200m,
    input  logic        rst_200m,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    input  logic        preamble_suppress,
    input  logic        opendrain_mode,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        mdio_in,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    logic [2:0]           state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    mdio_cmd_t            cmd_q, cmd_d;
    logic                 rd_q, rd_d;
    logic                 od_q, od_d;
    logic                 err_q, err_d;
    logic [15:0]          shift_q, shift_d;
    logic [15:0]          rdata_q, rdata_d;
    logic                 sync1_q, sync2_q;
    logic                 mdio_out_q, mdio_out_d;
    logic                 mdio_oen_q, mdio_oen_d;
    logic                 cmd_ready_q, busy_q, rsp_valid_q, rsp_err_q;

    logic                 accept_c, legal_c, run_c;
    logic                 rise_en_c, fall_en_c;
    logic [13:0]          hdr_c;
    logic                 drv_c, bit_c;

    assign accept_c = cmd_valid && cmd_ready_q && (state_q == S_IDLE);
    assign legal_c  = op_is_legal(cmd_c45, cmd_op);
    // Counting starts in the accept cycle so the first bit gets a full low half
    assign run_c    = (accept_c && legal_c) ||
                      (state_q inside {S_PRE, S_HDR, S_TA, S_DATA});

    mdio_mdc_gen #(
        .MDC_DIV(MDC_DIV)
    ) u_mdc_gen (
        .clk_i       (clk_200m),
        .rst_i       (rst_200m),
        .run_i       (run_c),
        .mdc_o       (mdc),
        .rise_en_c_o (rise_en_c),
        .fall_en_c_o (fall_en_c)
    );

    // Next-state, capture and line-bit selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        rd_d    = rd_q;
        od_d    = od_q;
        err_d   = err_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        drv_c   = 1'b0;
        bit_c   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    cmd_d = {cmd_c45, cmd_op, cmd_phyad, cmd_regad, cmd_wdata};
                    rd_d  = op_is_read(cmd_c45, cmd_op);
                    od_d  = opendrain_mode;
                    err_d = !legal_c;
                    cnt_d = '0;
                    if (!legal_c) begin
                        state_d = S_DONE;
                    end else if (preamble_suppress) begin
                        state_d = S_HDR;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: begin
                if (fall_en_c) begin
                    if (cnt_q == BIT_CNT_W'(PRE_BITS - 1)) begin
                        state_d = S_HDR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            S_HDR: begin
                if (fall_en_c) begin
                    if (cnt_q == BIT_CNT_W'(HDR_BITS - 1)) begin
                        state_d = S_TA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            S_TA: begin
                if (fall_en_c) begin
                    if (cnt_q == BIT_CNT_W'(TA_BITS - 1)) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (rise_en_c && rd_q) begin
                    shift_d = {shift_q[14:0], sync2_q};
                end
                if (fall_en_c) begin
                    if (cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        // last sample was taken on the preceding rising edge
                        if (rd_q) begin
                            rdata_d = shift_q;
                        end
                    end else begin
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hdr_c = {(cmd_d.c45 ? ST_C45 : ST_C22), cmd_d.op, cmd_d.phyad, cmd_d.regad};

        // Line value for the bit that will be on the wire next cycle
        case (state_d)
            S_PRE: begin
                drv_c = 1'b1;
                bit_c = 1'b1;
            end
            S_HDR: begin
                drv_c = 1'b1;
                bit_c = hdr_c[4'(HDR_BITS - 1) - cnt_d[3:0]];
            end
            S_TA: begin
                drv_c = !rd_d;
                bit_c = (cnt_d == '0);
            end
            S_DATA: begin
                drv_c = !rd_d;
                bit_c = cmd_d.wdata[4'(DATA_BITS - 1) - cnt_d[3:0]];
            end
            default: begin
                drv_c = 1'b0;
                bit_c = 1'b1;
            end
        endcase

        // Open-drain: a 1 is produced by releasing the line
        mdio_out_d = drv_c ? (od_d ? 1'b0 : bit_c) : 1'b1;
        mdio_oen_d = !drv_c || (od_d && bit_c);
    end

    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            rd_q        <= 1'b0;
            od_q        <= 1'b0;
            err_q       <= 1'b0;
            shift_q     <= '0;
            rdata_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            mdio_out_q  <= 1'b1;
            mdio_oen_q  <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            rd_q        <= rd_d;
            od_q        <= od_d;
            err_q       <= err_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            sync1_q     <= mdio_in;
            sync2_q     <= sync1_q;
            mdio_out_q  <= mdio_out_d;
            mdio_oen_q  <= mdio_oen_d;
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            rsp_valid_q <= (state_d == S_DONE);
            rsp_err_q   <= (state_d == S_DONE) && err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign mdio_out  = mdio_out_q;
    assign mdio_oen  = mdio_oen_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: directed frames plus randomized commands, each
// compared cycle by cycle against a bit-list model of the expected frame.
module tb_mdio_master;

    localparam int D = 8;
    localparam int H = D / 2;

    logic        clk_200m;
    logic        rst_200m;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_c45;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
    logic        preamble_suppress;
    logic        opendrain_mode;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oen;
    logic        mdio_in;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    mdio_master #(.MDC_DIV(D)) dut (
        .clk_200m          (clk_200m),
        .rst_200m          (rst_200m),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_c45           (cmd_c45),
        .cmd_op            (cmd_op),
        .cmd_phyad         (cmd_phyad),
        .cmd_regad         (cmd_regad),
        .cmd_wdata         (cmd_wdata),
        .preamble_suppress (preamble_suppress),
        .opendrain_mode    (opendrain_mode),
        .mdc               (mdc),
        .mdio_out          (mdio_out),
        .mdio_oen          (mdio_oen),
        .mdio_in           (mdio_in),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .busy              (busy)
    );

    initial clk_200m = 1'b0;
    always #5 clk_200m = ~clk_200m;

    int          n_vec;
    int          n_miss;
    logic [15:0] last_rd;
    logic [63:0] line_cap;
    bit          m_val[$];
    bit          m_drv[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Append n bits of v, MSB first, to the expected-frame bit list
    task automatic add_bits(input logic [15:0] v, input int n, input bit drv);
        for (int i = n - 1; i >= 0; i--) begin
            m_val.push_back(v[i]);
            m_drv.push_back(drv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mdc"},      mdc, 0);
        check_eq({tag, "_out"},      mdio_out, 1);
        check_eq({tag, "_oen"},      mdio_oen, 1);
        check_eq({tag, "_ready"},    cmd_ready, 0);
        check_eq({tag, "_busy"},     busy, 0);
        check_eq({tag, "_rspvalid"}, rsp_valid, 0);
        check_eq({tag, "_rsperr"},   rsp_err, 0);
        check_eq({tag, "_rdata"},    rsp_rdata, 0);
    endtask

    // Issue one command and check every cycle of its frame against the model.
    // abort_bit >= 0 asserts reset partway through that bit instead.
    task automatic run_frame(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] wd, input logic ps,
                             input logic od, input logic [15:0] rdv, input int abort_bit);
        logic       legal;
        logic       is_rd;
        logic [1:0] st;
        int         nbits;
        int         fd;
        int         last;
        int         k;
        bit         exp_oen;

        legal = c45 || (op == 2'b01) || (op == 2'b10);
        is_rd = c45 ? op[1] : (op == 2'b10);
        st    = c45 ? 2'b00 : 2'b01;
        m_val.delete();
        m_drv.delete();
        line_cap = '0;
        if (!ps) begin
            add_bits(16'hFFFF, 16, 1'b1);
            add_bits(16'hFFFF, 16, 1'b1);
        end
        add_bits({14'b0, st}, 2, 1'b1);
        add_bits({14'b0, op}, 2, 1'b1);
        add_bits({11'b0, phy}, 5, 1'b1);
        add_bits({11'b0, rg}, 5, 1'b1);
        if (is_rd) begin
            add_bits(16'h0000, 2, 1'b0);
            add_bits(16'h0000, 16, 1'b0);
        end else begin
            add_bits(16'h0002, 2, 1'b1);
            add_bits(wd, 16, 1'b1);
        end
        nbits = m_val.size();
        fd    = nbits - 16;
        last  = nbits * D;

        check_eq("ready_idle", cmd_ready, 1);
        cmd_c45           = c45;
        cmd_op            = op;
        cmd_phyad         = phy;
        cmd_regad         = rg;
        cmd_wdata         = wd;
        preamble_suppress = ps;
        opendrain_mode    = od;
        cmd_valid         = 1'b1;

        if (!legal) begin
            @(negedge clk_200m);
            cmd_valid = 1'b0;
            check_eq("illegal_rspvalid", rsp_valid, 1);
            check_eq("illegal_rsperr",   rsp_err, 1);
            check_eq("illegal_mdc",      mdc, 0);
            check_eq("illegal_ready",    cmd_ready, 0);
            check_eq("illegal_rdata",    rsp_rdata, last_rd);
            for (int j = 0; j < D; j++) begin
                @(negedge clk_200m);
                check_eq("illegal_after", {mdc, rsp_valid, cmd_ready, busy}, 4'b0010);
            end
            return;
        end

        for (int j = 1; j <= last + 1; j++) begin
            @(negedge clk_200m);
            // Busy master must ignore a still-asserted request with changing fields
            if (j < last) begin
                cmd_c45   = 1'($urandom);
                cmd_op    = 2'($urandom);
                cmd_phyad = 5'($urandom);
                cmd_regad = 5'($urandom);
                cmd_wdata = 16'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end

            if (j == abort_bit * D + 2) begin
                rst_200m  = 1'b1;
                cmd_valid = 1'b0;
                mdio_in   = 1'b1;
                @(negedge clk_200m);
                check_reset_outputs("abort_rst1");
                @(negedge clk_200m);
                check_reset_outputs("abort_rst2");
                rst_200m = 1'b0;
                last_rd  = '0;
                @(negedge clk_200m);
                check_eq("abort_ready", cmd_ready, 1);
                check_eq("abort_busy",  busy, 0);
                for (int q = 0; q < 600; q++) begin
                    @(negedge clk_200m);
                    check_eq("abort_quiet", {rsp_valid, mdc, mdio_oen}, 3'b001);
                end
                return;
            end

            if (j < last) begin
                k       = j / D;
                exp_oen = !m_drv[k] || (od && m_val[k]);
                check_eq("mdc",       mdc, ((j % D) >= H) ? 1 : 0);
                check_eq("oen",       mdio_oen, exp_oen);
                if (!exp_oen) begin
                    check_eq("out", mdio_out, m_val[k] && !od);
                end
                check_eq("busy",      busy, 1);
                check_eq("ready_busy", cmd_ready, 0);
                check_eq("rspvalid_early", rsp_valid, 0);
                if ((j % D) == H) begin
                    line_cap = {line_cap[62:0], (mdio_oen ? 1'b1 : mdio_out)};
                end
                mdio_in = (is_rd && k >= fd) ? rdv[15 - (k - fd)] : 1'b1;
            end else if (j == last) begin
                if (is_rd) begin
                    last_rd = rdv;
                end
                check_eq("done_rspvalid", rsp_valid, 1);
                check_eq("done_rsperr",   rsp_err, 0);
                check_eq("done_mdc",      mdc, 0);
                check_eq("done_oen",      mdio_oen, 1);
                check_eq("done_busy",     busy, 1);
                check_eq("done_rdata",    rsp_rdata, last_rd);
                mdio_in = 1'b1;
            end else begin
                check_eq("post_rspvalid", rsp_valid, 0);
                check_eq("post_ready",    cmd_ready, 1);
                check_eq("post_busy",     busy, 0);
                check_eq("post_rdata",    rsp_rdata, last_rd);
            end
        end
    endtask

    initial begin
        n_vec             = 0;
        n_miss            = 0;
        last_rd           = '0;
        line_cap          = '0;
        rst_200m          = 1'b1;
        cmd_valid         = 1'b0;
        cmd_c45           = 1'b0;
        cmd_op            = 2'b00;
        cmd_phyad         = '0;
        cmd_regad         = '0;
        cmd_wdata         = '0;
        preamble_suppress = 1'b0;
        opendrain_mode    = 1'b0;
        mdio_in           = 1'b1;

        repeat (3) @(negedge clk_200m);
        check_reset_outputs("reset");
        rst_200m = 1'b0;
        @(negedge clk_200m);
        check_eq("rel_ready", cmd_ready, 1);
        check_eq("rel_busy",  busy, 0);
        repeat (D) begin
            @(negedge clk_200m);
            check_eq("idle_mdc", mdc, 0);
        end

        // Clause 22 write with preamble: full line image is known in advance
        run_frame(1'b0, 2'b01, 5'h03, 5'h1F, 16'hA5C3, 1'b0, 1'b0, 16'h0000, -1);
        check_eq("c22w_line", line_cap, 64'hFFFF_FFFF_51FE_A5C3);

        // Clause 22 read
        run_frame(1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 1'b0, 16'h1234, -1);
        check_eq("c22r_rdata", rsp_rdata, 16'h1234);

        // Clause 45 address then read, no preamble
        run_frame(1'b1, 2'b00, 5'h07, 5'h01, 16'h0100, 1'b1, 1'b0, 16'h0000, -1);
        check_eq("c45a_st", line_cap[31:30], 2'b00);
        run_frame(1'b1, 2'b11, 5'h07, 5'h01, 16'h0000, 1'b1, 1'b0, 16'hBEEF, -1);
        check_eq("c45r_st", line_cap[31:30], 2'b00);
        check_eq("c45r_rdata", rsp_rdata, 16'hBEEF);

        // Illegal Clause 22 opcode
        run_frame(1'b0, 2'b11, 5'h04, 5'h05, 16'h0000, 1'b0, 1'b0, 16'h0000, -1);

        // Open-drain write
        run_frame(1'b0, 2'b01, 5'h15, 5'h0A, 16'h5AF0, 1'b1, 1'b1, 16'h0000, -1);

        // Reset in the middle of bit 40, then a clean read
        run_frame(1'b0, 2'b01, 5'h09, 5'h11, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 40);
        run_frame(1'b0, 2'b10, 5'h1E, 5'h03, 16'h0000, 1'b1, 1'b0, 16'hC0DE, -1);

        // Randomized commands
        for (int n = 0; n < 12; n++) begin
            run_frame(1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
                      16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
